// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - raster coordinate, sync and frame-count bus from the timing generator
interface video_timing_gen_if;
  logic [15:0] o_x;
  logic [15:0] o_y;
  logic        o_de;
  logic        o_h_sync;
  logic        o_v_sync;
  logic        o_line_start;
  logic        o_frame_start;
  logic [15:0] o_frame_cnt;

  modport master (
    output o_x, o_y, o_de, o_h_sync, o_v_sync,
    output o_line_start, o_frame_start, o_frame_cnt
  );

  modport slave (
    input o_x, o_y, o_de, o_h_sync, o_v_sync,
    input o_line_start, o_frame_start, o_frame_cnt
  );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - pixel/line counters with registered coordinate, sync, DE and frame strobes
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pix_en,
  video_timing_gen_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  localparam logic [15:0] H_LAST    = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST    = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT16   = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT16   = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG16  = 16'(HS_BEG);
  localparam logic [15:0] HS_END16  = 16'(HS_END);
  localparam logic [15:0] VS_BEG16  = 16'(VS_BEG);
  localparam logic [15:0] VS_END16  = 16'(VS_END);

  generate
    if (H_SYNC < 1 || V_SYNC < 1 || H_TOTAL < 1 || V_TOTAL < 1 ||
        H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_param_check
      $error("video_timing_gen: illegal timing parameters");
    end
  endgenerate

  logic [15:0] h_cnt;
  logic [15:0] v_cnt;
  logic        started;

  logic h_last;
  logic at_origin;
  logic h_in_sync;
  logic v_in_sync;
  logic in_active;

  always_comb begin
    h_last    = (h_cnt == H_LAST);
    at_origin = (h_cnt == 16'd0) && (v_cnt == 16'd0);
    h_in_sync = (h_cnt >= HS_BEG16) && (h_cnt < HS_END16);
    v_in_sync = (v_cnt >= VS_BEG16) && (v_cnt < VS_END16);
    in_active = (h_cnt < H_ACT16) && (v_cnt < V_ACT16);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt <= 16'd0;
      v_cnt <= 16'd0;
    end else if (i_pix_en) begin
      if (h_last) begin
        h_cnt <= 16'd0;
        v_cnt <= (v_cnt == V_LAST) ? 16'd0 : v_cnt + 16'd1;
      end else begin
        h_cnt <= h_cnt + 16'd1;
      end
    end
  end

  // Outputs decode the counter state of the previous tick; the first frame
  // after reset is not counted, so frame_cnt only moves once started is set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vid.o_x           <= 16'd0;
      vid.o_y           <= 16'd0;
      vid.o_de          <= 1'b0;
      vid.o_h_sync      <= ~H_POL;
      vid.o_v_sync      <= ~V_POL;
      vid.o_line_start  <= 1'b0;
      vid.o_frame_start <= 1'b0;
      vid.o_frame_cnt   <= 16'd0;
      started           <= 1'b0;
    end else if (i_pix_en) begin
      vid.o_x           <= h_cnt;
      vid.o_y           <= v_cnt;
      vid.o_de          <= in_active;
      vid.o_h_sync      <= h_in_sync ? H_POL : ~H_POL;
      vid.o_v_sync      <= v_in_sync ? V_POL : ~V_POL;
      vid.o_line_start  <= (h_cnt == 16'd0);
      vid.o_frame_start <= at_origin;
      started           <= 1'b1;
      if (at_origin && started) begin
        vid.o_frame_cnt <= vid.o_frame_cnt + 16'd1;
      end
    end else begin
      vid.o_line_start  <= 1'b0;
      vid.o_frame_start <= 1'b0;
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed self-checking bench for video_timing_gen
module tb_video_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, pix_en;
  logic rst_d, pix_en_d;
  logic rst_t, pix_en_t;

  int checks = 0;
  int errors = 0;
  int k;
  bit found;

  video_timing_gen_if vif ();
  video_timing_gen_if vif_d ();
  video_timing_gen_if vif_t ();

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .vid(vif)
  );

  video_timing_gen #(
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_dut_def (
    .i_clk(clk), .i_rst_n(rst_d), .i_pix_en(pix_en_d), .vid(vif_d)
  );

  video_timing_gen #(
    .H_ACTIVE(0), .H_FP(0), .H_SYNC(1), .H_BP(0),
    .V_ACTIVE(0), .V_FP(0), .V_SYNC(1), .V_BP(0)
  ) u_dut_tiny (
    .i_clk(clk), .i_rst_n(rst_t), .i_pix_en(pix_en_t), .vid(vif_t)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_x"},  32'(vif.o_x), 32'd0);
    chk({tag, "_y"},  32'(vif.o_y), 32'd0);
    chk({tag, "_de"}, 32'(vif.o_de), 32'd0);
    chk({tag, "_hs"}, 32'(vif.o_h_sync), 32'd0);
    chk({tag, "_vs"}, 32'(vif.o_v_sync), 32'd0);
    chk({tag, "_ls"}, 32'(vif.o_line_start), 32'd0);
    chk({tag, "_fs"}, 32'(vif.o_frame_start), 32'd0);
    chk({tag, "_fc"}, 32'(vif.o_frame_cnt), 32'd0);
  endtask

  // Expected main-instance outputs after k counted ticks (14 clocks/line, 7 lines/frame).
  task automatic chk_main(input int kk, input bit en);
    int ex, ey;
    ex = kk % 14;
    ey = (kk / 14) % 7;
    chk("x",  32'(vif.o_x), 32'(ex));
    chk("y",  32'(vif.o_y), 32'(ey));
    chk("de", 32'(vif.o_de), 32'((ex < 8) && (ey < 4)));
    chk("hs", 32'(vif.o_h_sync), 32'((ex == 10) || (ex == 11)));
    chk("vs", 32'(vif.o_v_sync), 32'(ey == 5));
    chk("ls", 32'(vif.o_line_start), 32'(en && (ex == 0)));
    chk("fs", 32'(vif.o_frame_start), 32'(en && (ex == 0) && (ey == 0)));
    chk("fc", 32'(vif.o_frame_cnt), 32'(kk / 98));
  endtask

  initial begin
    rst_n = 1'b0; pix_en = 1'b0;
    rst_d = 1'b0; pix_en_d = 1'b0;
    rst_t = 1'b0; pix_en_t = 1'b0;
    repeat (3) tick();
    chk_reset("rst");
    chk("def_rst_hs", 32'(vif_d.o_h_sync), 32'd1);
    chk("def_rst_vs", 32'(vif_d.o_v_sync), 32'd1);

    // First enabled tick after release emits the origin with both strobes.
    rst_n = 1'b1;
    pix_en = 1'b1;
    k = 0;
    tick();
    chk_main(k, 1'b1);
    for (int i = 0; i < 120; i++) begin
      tick();
      k++;
      chk_main(k, 1'b1);
    end

    // Alternate enable: counters move only on enabled ticks, strobes drop otherwise.
    for (int i = 0; i < 20; i++) begin
      pix_en = (i % 2 == 1);
      tick();
      if (pix_en) k++;
      chk_main(k, pix_en);
    end

    // Run to x=9,y=2 then reset mid-cycle.
    pix_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      k++;
      chk_main(k, 1'b1);
      if (vif.o_x == 16'd9 && vif.o_y == 16'd2) found = 1'b1;
    end
    chk("reach_x9y2", 32'(found), 32'd1);
    chk("pre_rst_fc", 32'(vif.o_frame_cnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    #1;
    rst_n = 1'b1;
    k = 0;
    tick();
    chk_main(k, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
      k++;
      chk_main(k, 1'b1);
    end

    // Default 1650x750 timing with active-low syncs: one line plus wrap.
    rst_d = 1'b1;
    pix_en_d = 1'b1;
    for (int j = 0; j <= 1650; j++) begin
      int ex;
      tick();
      ex = j % 1650;
      chk("def_x", 32'(vif_d.o_x), 32'(ex));
      chk("def_y", 32'(vif_d.o_y), 32'(j / 1650));
      chk("def_hs", 32'(vif_d.o_h_sync), 32'(!((ex >= 1390) && (ex <= 1429))));
      chk("def_vs", 32'(vif_d.o_v_sync), 32'd1);
      chk("def_de", 32'(vif_d.o_de), 32'(ex < 1280));
    end
    pix_en_d = 1'b0;

    // One-pixel frame: every tick is a frame start, so frame_cnt wraps quickly.
    rst_t = 1'b1;
    pix_en_t = 1'b1;
    tick();
    chk("tiny_fs0", 32'(vif_t.o_frame_start), 32'd1);
    chk("tiny_fc0", 32'(vif_t.o_frame_cnt), 32'd0);
    tick();
    chk("tiny_fc1", 32'(vif_t.o_frame_cnt), 32'd1);
    chk("tiny_hs", 32'(vif_t.o_h_sync), 32'd1);
    chk("tiny_vs", 32'(vif_t.o_v_sync), 32'd1);
    repeat (65534) tick();
    chk("tiny_fc_max", 32'(vif_t.o_frame_cnt), 32'hFFFF);
    tick();
    chk("tiny_fc_wrap", 32'(vif_t.o_frame_cnt), 32'd0);
    chk("tiny_fs_wrap", 32'(vif_t.o_frame_start), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
